// File: rtl/instr_encoder.sv
// RV32 instruction encoder: field bundle in, one 32-bit word per memory write out, 1-cycle latency.
// Optional macro IMM_RANGE_CHECK_EN drops bundles whose immediate does not fit its class.
module instr_encoder #(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [4:0]        rd,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       instr_count,
   output logic              err_fmt,
   output logic              err_imm
);

   localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_L = 3'd2;
   localparam logic [2:0] FMT_S = 3'd3;
   localparam logic [2:0] FMT_B = 3'd4;
   localparam logic [2:0] FMT_U = 3'd5;

   logic              r_valid;
   logic [31:0]       r_instr;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_count;
   logic              r_err_fmt;

   logic [31:0]       w_instr;
   logic              w_fmt_ok;
   logic              w_imm_ok;
   logic              w_accept;
   logic              w_deliver;
   logic              w_load;

   always_comb begin
      w_instr = 32'd0;
      case (fmt)
         FMT_R: w_instr = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
         FMT_I: w_instr = {imm[11:0], rs1, funct3, rd, 7'b0010011};
         FMT_L: w_instr = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
         FMT_S: w_instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
         FMT_B: w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
         FMT_U: w_instr = {imm[31:12], rd, 7'b0110111};
         default: w_instr = 32'd0;
      endcase
   end

   assign w_fmt_ok  = (fmt <= FMT_U);
   assign in_ready  = !r_valid || out_ready;
   // clear overrides both handshakes: nothing accepted, nothing counted as delivered
   assign w_accept  = in_valid && in_ready && !clear;
   assign w_deliver = r_valid && out_ready && !clear;
   assign w_load    = w_accept && w_fmt_ok && w_imm_ok;

`ifdef IMM_RANGE_CHECK_EN
   logic r_err_imm;

   always_comb begin
      w_imm_ok = 1'b1;
      case (fmt)
         FMT_I, FMT_L, FMT_S: w_imm_ok = (imm[31:11] == {21{imm[11]}});
         FMT_B:               w_imm_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
         FMT_U:               w_imm_ok = (imm[11:0] == 12'd0);
         default:             w_imm_ok = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err_imm <= 1'b0;
      else        r_err_imm <= w_accept && w_fmt_ok && !w_imm_ok;
   end

   assign err_imm = r_err_imm;
`else
   assign w_imm_ok = 1'b1;
   assign err_imm  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_instr   <= 32'd0;
         r_addr    <= LP_BASE;
         r_count   <= 16'd0;
         r_err_fmt <= 1'b0;
      end else if (clear) begin
         r_valid   <= 1'b0;
         r_instr   <= 32'd0;
         r_addr    <= LP_BASE;
         r_count   <= 16'd0;
         r_err_fmt <= 1'b0;
      end else begin
         r_err_fmt <= w_accept && !w_fmt_ok;
         // r_addr always names the slot of the word in (or next entering) the stage
         if (w_deliver) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
         end
         if (w_load) begin
            r_valid <= 1'b1;
            r_instr <= w_instr;
         end else if (w_deliver) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_valid;
   assign out_instr   = r_instr;
   assign out_addr    = r_addr;
   assign instr_count = r_count;
   assign err_fmt     = r_err_fmt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (ADDR_W=4): directed vectors plus randomized traffic against a word-queue model.
module tb_instr_encoder;

   localparam int AW      = 4;
   localparam int TB_BASE = 0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    fmt;
   logic [4:0]    rs1, rs2, rd;
   logic [2:0]    funct3;
   logic [6:0]    funct7;
   logic [31:0]   imm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic [15:0]   instr_count;
   logic          err_fmt;
   logic          err_imm;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   int          delivered;
   int          exp_count;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(AW), .BASE_ADDR(TB_BASE)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .rs1(rs1), .rs2(rs2), .rd(rd),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .instr_count(instr_count), .err_fmt(err_fmt), .err_imm(err_imm)
   );

   // Reference encoding built from field weights (bit position = power of two).
   function automatic logic [31:0] ref_encode(input int unsigned f, input int unsigned r1,
         input int unsigned r2, input int unsigned d, input int unsigned f3,
         input int unsigned f7, input int unsigned im);
      int unsigned lo12 = im % 4096;
      int unsigned b    = im % 8192;
      case (f)
         0: return 51 + d*128 + f3*4096 + r1*32768 + r2*1048576 + f7*33554432;
         1: return 19 + d*128 + f3*4096 + r1*32768 + lo12*1048576;
         2: return 3 + d*128 + 2*4096 + r1*32768 + lo12*1048576;
         3: return 35 + (lo12 % 32)*128 + 2*4096 + r1*32768 + r2*1048576 + (lo12 / 32)*33554432;
         4: return 99 + ((b / 2048) % 2)*128 + ((b / 2) % 16)*256 + f3*4096 + r1*32768
                   + r2*1048576 + ((b / 32) % 64)*33554432 + (b / 4096)*32'h8000_0000;
         5: return 55 + d*128 + (im / 4096)*4096;
         default: return 0;
      endcase
   endfunction

   function automatic bit imm_legal(input int unsigned f, input logic [31:0] im);
`ifdef IMM_RANGE_CHECK_EN
      int s = $signed(im);
      case (f)
         1, 2, 3: return (s >= -2048) && (s <= 2047);
         4:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
         5:       return (im % 4096) == 0;
         default: return 1'b1;
      endcase
`else
      return (f <= 7);
`endif
   endfunction

   function automatic logic [AW-1:0] exp_addr();
      return AW'((TB_BASE + 4*delivered) % (1 << AW));
   endfunction

   task automatic model_reset();
      exp_q.delete();
      delivered = 0;
      exp_count = 0;
   endtask

   // One clock of traffic; the scoreboard compares every delivered word and every pulse.
   task automatic run_cycle(input bit v, input bit rdy, input bit clr, input logic [2:0] f,
         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
      bit slot_free, acc, nf, ni;
      in_valid = v; out_ready = rdy; clear = clr;
      fmt = f; rs1 = r1; rs2 = r2; rd = d; funct3 = f3; funct7 = f7; imm = im;
      @(negedge clk);
      slot_free = (exp_q.size() == 0) || rdy;
      n_checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
         n_fail++; $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
      end
      n_checks++;
      if (in_ready !== slot_free) begin
         n_fail++; $display("FAIL in_ready: got %b expected %b", in_ready, slot_free);
      end
      if (exp_q.size() != 0 && rdy && !clr) begin
         n_checks++;
         if (out_instr !== exp_q[0]) begin
            n_fail++; $display("FAIL deliver_instr: got %h expected %h", out_instr, exp_q[0]);
         end
         n_checks++;
         if (out_addr !== exp_addr()) begin
            n_fail++; $display("FAIL deliver_addr: got %0d expected %0d", out_addr, exp_addr());
         end
         void'(exp_q.pop_front());
         delivered++;
         if (exp_count < 65535) exp_count++;
      end
      acc = v && slot_free && !clr;
      nf = 1'b0; ni = 1'b0;
      if (acc) begin
         if (f > 5) nf = 1'b1;
         else if (!imm_legal(f, im)) ni = 1'b1;
         else exp_q.push_back(ref_encode(f, r1, r2, d, f3, f7, im));
      end
      if (clr) model_reset();
      @(posedge clk); #1;
      n_checks++;
      if (err_fmt !== nf) begin
         n_fail++; $display("FAIL err_fmt: got %b expected %b", err_fmt, nf);
      end
      n_checks++;
      if (err_imm !== ni) begin
         n_fail++; $display("FAIL err_imm: got %b expected %b", err_imm, ni);
      end
      n_checks++;
      if (instr_count !== 16'(exp_count)) begin
         n_fail++; $display("FAIL instr_count: got %0d expected %0d", instr_count, exp_count);
      end
   endtask

   task automatic idle(input bit rdy);
      run_cycle(1'b0, rdy, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      fmt = 3'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_instr, out_addr, instr_count, err_fmt, err_imm} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b i=%h a=%0d c=%0d ef=%b ei=%b expected all zero",
                  out_valid, out_instr, out_addr, instr_count, err_fmt, err_imm);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_load();
      run_cycle(1'b1, 1'b1, 1'b0, 3'd2, 5'd2, 5'd0, 5'd5, 3'd0, 7'd0, 32'd8);
      n_checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h00812283 || out_addr !== 4'd0) begin
         n_fail++; $display("FAIL load_word: got v=%b %h @%0d expected 1 00812283 @0",
                            out_valid, out_instr, out_addr);
      end
      idle(1'b1);
   endtask

   task automatic test_back_to_back();
      run_cycle(1'b1, 1'b1, 1'b0, 3'd3, 5'd2, 5'd5, 5'd0, 3'd0, 7'd0, 32'd12);
      n_checks++;
      if (out_instr !== 32'h00512623 || out_addr !== 4'd4) begin
         n_fail++; $display("FAIL store_word: got %h @%0d expected 00512623 @4", out_instr, out_addr);
      end
      run_cycle(1'b1, 1'b1, 1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== 4'd8) begin
         n_fail++; $display("FAIL b2b_word: got v=%b %h @%0d expected 1 002081B3 @8",
                            out_valid, out_instr, out_addr);
      end
      idle(1'b1);
   endtask

   task automatic test_branch_upper();
      run_cycle(1'b1, 1'b1, 1'b0, 3'd4, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8);
      n_checks++;
      if (out_instr !== 32'h00208463) begin
         n_fail++; $display("FAIL branch_word: got %h expected 00208463", out_instr);
      end
      run_cycle(1'b1, 1'b1, 1'b0, 3'd5, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'h12345000);
      n_checks++;
      if (out_instr !== 32'h123450B7) begin
         n_fail++; $display("FAIL upper_word: got %h expected 123450B7", out_instr);
      end
      idle(1'b1);
   endtask

   task automatic test_backpressure();
      logic [31:0] held_i;
      logic [AW-1:0] held_a;
      int c0;
      c0 = exp_count;
      run_cycle(1'b1, 1'b0, 1'b0, 3'd1, 5'd7, 5'd0, 5'd9, 3'd4, 7'd0, 32'h0000_0123);
      held_i = out_instr; held_a = out_addr;
      for (int k = 0; k < 3; k++) begin
         run_cycle(1'b1, 1'b0, 1'b0, 3'd0, 5'd4, 5'd6, 5'd8, 3'd1, 7'h20, 32'd0);
         n_checks++;
         if (in_ready !== 1'b0 || out_instr !== held_i || out_addr !== held_a) begin
            n_fail++; $display("FAIL stall_hold: got rdy=%b %h @%0d expected 0 %h @%0d",
                               in_ready, out_instr, out_addr, held_i, held_a);
         end
      end
      run_cycle(1'b1, 1'b1, 1'b0, 3'd0, 5'd4, 5'd6, 5'd8, 3'd1, 7'h20, 32'd0);
      idle(1'b1);
      n_checks++;
      if (instr_count !== 16'(c0 + 2)) begin
         n_fail++; $display("FAIL stall_count: got %0d expected %0d", instr_count, c0 + 2);
      end
   endtask

   task automatic test_illegal_fmt();
      int c0;
      c0 = exp_count;
      run_cycle(1'b1, 1'b1, 1'b0, 3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
      n_checks++;
      if (err_fmt !== 1'b1 || out_valid !== 1'b0 || instr_count !== 16'(c0)) begin
         n_fail++; $display("FAIL illegal_fmt: got ef=%b v=%b c=%0d expected 1 0 %0d",
                            err_fmt, out_valid, instr_count, c0);
      end
      idle(1'b1);
      run_cycle(1'b1, 1'b1, 1'b0, 3'd6, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
      idle(1'b1);
   endtask

   task automatic test_wrap();
      logic [AW-1:0] want[5] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
      run_cycle(1'b0, 1'b1, 1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      for (int k = 0; k < 5; k++) begin
         run_cycle(1'b1, 1'b1, 1'b0, 3'd1, 5'(k), 5'd0, 5'(k + 1), 3'd0, 7'd0, 32'(k));
         n_checks++;
         if (out_addr !== want[k]) begin
            n_fail++; $display("FAIL wrap_addr%0d: got %0d expected %0d", k, out_addr, want[k]);
         end
      end
      idle(1'b1);
   endtask

   task automatic test_imm_range();
      run_cycle(1'b1, 1'b1, 1'b0, 3'd1, 5'd3, 5'd0, 5'd4, 3'd0, 7'd0, 32'h0000_0800);
      n_checks++;
`ifdef IMM_RANGE_CHECK_EN
      if (err_imm !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL imm_range: got ei=%b v=%b expected 1 0", err_imm, out_valid);
      end
`else
      if (err_imm !== 1'b0 || out_valid !== 1'b1 || out_instr[31:20] !== 12'h800) begin
         n_fail++; $display("FAIL imm_trunc: got ei=%b v=%b imm=%h expected 0 1 800",
                            err_imm, out_valid, out_instr[31:20]);
      end
`endif
      idle(1'b1);
   endtask

   task automatic test_clear();
      run_cycle(1'b1, 1'b0, 1'b0, 3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
      run_cycle(1'b1, 1'b1, 1'b1, 3'd0, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 32'd0);
      n_checks++;
      if (out_valid !== 1'b0 || out_addr !== 4'(TB_BASE) || instr_count !== 16'd0) begin
         n_fail++; $display("FAIL clear: got v=%b a=%0d c=%0d expected 0 %0d 0",
                            out_valid, out_addr, instr_count, TB_BASE);
      end
      idle(1'b1);
   endtask

   task automatic test_reset_mid_stall();
      run_cycle(1'b1, 1'b0, 1'b0, 3'd5, 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 32'hABCDE000);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_addr !== 4'(TB_BASE) || instr_count !== 16'd0) begin
         n_fail++; $display("FAIL async_reset: got v=%b a=%0d c=%0d expected 0 %0d 0",
                            out_valid, out_addr, instr_count, TB_BASE);
      end
      model_reset();
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_random();
      logic [31:0] im;
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0: im = $urandom;
            1: im = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: im = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
            default: im = $urandom & 32'hFFFF_F000;
         endcase
         run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                   3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                   3'($urandom), 7'($urandom), im);
      end
      repeat (3) idle(1'b1);
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_branch_upper();
      test_backpressure();
      test_illegal_fmt();
      test_wrap();
      test_imm_range();
      test_clear();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
